// File: rtl/video_pkg.sv
// Shared types and constants for the test-pattern video source.
package video_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [1:0] {
        ModeSolid   = 2'd0,
        ModeBars    = 2'd1,
        ModeChecker = 2'd2,
        ModeRamp    = 2'd3
    } mode_e;

    localparam rgb_t BAR_COLORS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    function automatic int unsigned at_least_one(int unsigned x);
        return (x > 0) ? x : 1;
    endfunction

    // Counter width for values 0..range-1, never zero bits wide.
    function automatic int unsigned cnt_width(int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Registered video output bus: syncs, active flag, pixel data and start-of-frame.
interface video_timing_gen_if;
    import video_pkg::*;

    logic hs;
    logic vs;
    logic de;
    logic sof;
    rgb_t data;

    modport master (output hs, vs, de, sof, data);
    modport slave  (input  hs, vs, de, sof, data);

endinterface

// File: rtl/timing_counter.sv
// Raster h/v counters with combinational hs/vs/de/sof decode of the current position.
module timing_counter #(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned H_START  = 2008,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_TOTAL  = 2200,
    parameter int unsigned V_HEIGHT = 1080,
    parameter int unsigned V_START  = 1084,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_TOTAL  = 1125,
    parameter int unsigned HW       = video_pkg::cnt_width(H_TOTAL),
    parameter int unsigned VW       = video_pkg::cnt_width(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] h_o,
    output logic [VW-1:0] v_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          de_o,
    output logic          sof_o
);

    if (!(H_WIDTH < H_START)) begin : g_bad_h_start
        $error("H_WIDTH must be less than H_START");
    end
    if (!(H_START + H_SYNC <= H_TOTAL)) begin : g_bad_h_sync
        $error("H_START + H_SYNC must not exceed H_TOTAL");
    end
    if (!(V_HEIGHT < V_START)) begin : g_bad_v_start
        $error("V_HEIGHT must be less than V_START");
    end
    if (!(V_START + V_SYNC <= V_TOTAL)) begin : g_bad_v_sync
        $error("V_START + V_SYNC must not exceed V_TOTAL");
    end

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_last;
    logic          w_v_last;

    always_comb begin
        w_h_last = 32'(r_h) == H_TOTAL - 1;
        w_v_last = 32'(r_v) == V_TOTAL - 1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + VW'(1);
        end else begin
            r_h <= r_h + HW'(1);
        end
    end

    always_comb begin
        h_o   = r_h;
        v_o   = r_v;
        de_o  = (32'(r_h) < H_WIDTH) && (32'(r_v) < V_HEIGHT);
        hs_o  = (32'(r_h) >= H_START) && (32'(r_h) < H_START + H_SYNC);
        vs_o  = (32'(r_v) >= V_START) && (32'(r_v) < V_START + V_SYNC);
        sof_o = (r_h == '0) && (r_v == '0);
    end

endmodule

// File: rtl/video_timing_gen.sv
// Test-pattern video source: raster timing plus per-frame latched pattern generator,
// with all outputs registered one cycle after the counter position.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int unsigned H_WIDTH  = 1920,
    parameter int unsigned H_START  = 2008,
    parameter int unsigned H_SYNC   = 44,
    parameter int unsigned H_TOTAL  = 2200,
    parameter int unsigned V_HEIGHT = 1080,
    parameter int unsigned V_START  = 1084,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_TOTAL  = 1125,
    parameter int unsigned KH       = 30,
    parameter int unsigned KV       = 30
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         mode_i,
    input  rgb_t               color_i,
    video_timing_gen_if.master vid_o
);

    if (!(KH >= 1)) begin : g_bad_kh
        $error("KH must be at least 1");
    end
    if (!(KV >= 1)) begin : g_bad_kv
        $error("KV must be at least 1");
    end

    localparam int unsigned HW  = cnt_width(H_TOTAL);
    localparam int unsigned VW  = cnt_width(V_TOTAL);
    localparam int unsigned BW  = at_least_one(H_WIDTH / 8);
    localparam int unsigned RW  = at_least_one(H_WIDTH / 256);
    localparam int unsigned BPW = cnt_width(BW);
    localparam int unsigned RPW = cnt_width(RW);
    localparam int unsigned XPW = cnt_width(KH);
    localparam int unsigned YPW = cnt_width(KV);

    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic          w_hs, w_vs, w_de, w_sof;
    logic          w_line_end, w_frame_end;

    timing_counter #(
        .H_WIDTH  (H_WIDTH),
        .H_START  (H_START),
        .H_SYNC   (H_SYNC),
        .H_TOTAL  (H_TOTAL),
        .V_HEIGHT (V_HEIGHT),
        .V_START  (V_START),
        .V_SYNC   (V_SYNC),
        .V_TOTAL  (V_TOTAL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .h_o   (w_h),
        .v_o   (w_v),
        .hs_o  (w_hs),
        .vs_o  (w_vs),
        .de_o  (w_de),
        .sof_o (w_sof)
    );

    always_comb begin
        w_line_end  = 32'(w_h) == H_TOTAL - 1;
        w_frame_end = w_line_end && (32'(w_v) == V_TOTAL - 1);
    end

    mode_e r_mode;
    rgb_t  r_color;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mode  <= ModeSolid;
            r_color <= '0;
        end else if (w_sof) begin
            r_mode  <= mode_e'(mode_i);
            r_color <= color_i;
        end
    end

    // Tile index only matters through its parity, so x/y tile counters keep just bit 0.
    logic [BPW-1:0] r_bar_px;
    logic [2:0]     r_bar_idx;
    logic [RPW-1:0] r_ramp_px;
    logic [7:0]     r_gray;
    logic [XPW-1:0] r_tx_px;
    logic           r_tx;
    logic [YPW-1:0] r_ty_px;
    logic           r_ty;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
            r_ramp_px <= '0;
            r_gray    <= '0;
            r_tx_px   <= '0;
            r_tx      <= 1'b0;
            r_ty_px   <= '0;
            r_ty      <= 1'b0;
        end else if (w_line_end) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
            r_ramp_px <= '0;
            r_gray    <= '0;
            r_tx_px   <= '0;
            r_tx      <= 1'b0;
            if (w_frame_end) begin
                r_ty_px <= '0;
                r_ty    <= 1'b0;
            end else if (32'(r_ty_px) == KV - 1) begin
                r_ty_px <= '0;
                r_ty    <= ~r_ty;
            end else begin
                r_ty_px <= r_ty_px + YPW'(1);
            end
        end else begin
            if (32'(r_bar_px) == BW - 1) begin
                r_bar_px <= '0;
                if (r_bar_idx != 3'd7) begin
                    r_bar_idx <= r_bar_idx + 3'd1;
                end
            end else begin
                r_bar_px <= r_bar_px + BPW'(1);
            end
            if (32'(r_ramp_px) == RW - 1) begin
                r_ramp_px <= '0;
                if (r_gray != 8'hFF) begin
                    r_gray <= r_gray + 8'd1;
                end
            end else begin
                r_ramp_px <= r_ramp_px + RPW'(1);
            end
            if (32'(r_tx_px) == KH - 1) begin
                r_tx_px <= '0;
                r_tx    <= ~r_tx;
            end else begin
                r_tx_px <= r_tx_px + XPW'(1);
            end
        end
    end

    // Pixel (0,0) already uses the inputs being latched on that same edge.
    mode_e w_mode;
    rgb_t  w_color;
    rgb_t  w_pix;

    always_comb begin
        w_mode  = w_sof ? mode_e'(mode_i) : r_mode;
        w_color = w_sof ? color_i : r_color;
        w_pix   = '0;
        if (w_de) begin
            unique case (w_mode)
                ModeSolid:   w_pix = w_color;
                ModeBars:    w_pix = BAR_COLORS[r_bar_idx];
                ModeChecker: w_pix = (r_tx ^ r_ty) ? 24'h000000 : 24'hFFFFFF;
                ModeRamp:    w_pix = {3{r_gray}};
                default:     w_pix = '0;
            endcase
        end
    end

    logic r_hs, r_vs, r_de, r_sof;
    rgb_t r_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hs   <= 1'b0;
            r_vs   <= 1'b0;
            r_de   <= 1'b0;
            r_sof  <= 1'b0;
            r_data <= '0;
        end else begin
            r_hs   <= w_hs;
            r_vs   <= w_vs;
            r_de   <= w_de;
            r_sof  <= w_sof;
            r_data <= w_pix;
        end
    end

    assign vid_o.hs   = r_hs;
    assign vid_o.vs   = r_vs;
    assign vid_o.de   = r_de;
    assign vid_o.sof  = r_sof;
    assign vid_o.data = r_data;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: two small-raster instances (narrow, and 512-wide for the ramp) checked
// cycle by cycle against a raster model computed from plain position arithmetic.
module tb_video_timing_gen;

    localparam logic [23:0] BAR_TAB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

    typedef struct packed {
        logic        sof;
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
    } pix_t;

    typedef struct {
        int          h;
        int          v;
        logic [1:0]  mode;
        logic [23:0] color;
    } mstate_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'h0;
    logic [1:0]  nxt_mode = 2'd0;
    logic [23:0] nxt_color = 24'h0;
    logic        rel_pending = 1'b0;

    int checks = 0;
    int failures = 0;

    pix_t    q_a[$];
    pix_t    q_b[$];
    mstate_t ma, mb;

    always #5 clk = ~clk;

    video_timing_gen_if vid_a ();
    video_timing_gen_if vid_b ();

    video_timing_gen #(
        .H_WIDTH (8), .H_START (10), .H_SYNC (2), .H_TOTAL (12),
        .V_HEIGHT (4), .V_START (5), .V_SYNC (1), .V_TOTAL (6),
        .KH (2), .KV (2)
    ) dut_a (
        .clk_i   (clk),
        .rst_i   (rst),
        .mode_i  (mode),
        .color_i (color),
        .vid_o   (vid_a)
    );

    video_timing_gen #(
        .H_WIDTH (512), .H_START (514), .H_SYNC (2), .H_TOTAL (520),
        .V_HEIGHT (4), .V_START (5), .V_SYNC (1), .V_TOTAL (6),
        .KH (2), .KV (2)
    ) dut_b (
        .clk_i   (clk),
        .rst_i   (rst),
        .mode_i  (mode),
        .color_i (color),
        .vid_o   (vid_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pix_t ref_pixel(input int h, input int v, input int hw, input int hs0,
                                       input logic [1:0] m, input logic [23:0] c);
        pix_t p;
        int   idx;
        int   g;
        p.sof  = (h == 0) && (v == 0);
        p.hs   = (h >= hs0) && (h < hs0 + 2);
        p.vs   = (v == 5);
        p.de   = (h < hw) && (v < 4);
        p.data = 24'h0;
        if (p.de) begin
            case (m)
                2'd0: p.data = c;
                2'd1: begin
                    idx = h / ((hw / 8 > 0) ? hw / 8 : 1);
                    if (idx > 7) idx = 7;
                    p.data = BAR_TAB[idx];
                end
                2'd2: p.data = (((h / 2) + (v / 2)) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
                default: begin
                    g = h / ((hw / 256 > 0) ? hw / 256 : 1);
                    if (g > 255) g = 255;
                    p.data = {3{g[7:0]}};
                end
            endcase
        end
        return p;
    endfunction

    task automatic step(input mstate_t s, input int hw, input int hs0, input int htot,
                        output mstate_t n, output pix_t p);
        n = s;
        if (n.h == 0 && n.v == 0) begin
            n.mode  = mode;
            n.color = color;
        end
        p = ref_pixel(n.h, n.v, hw, hs0, n.mode, n.color);
        n.h++;
        if (n.h == htot) begin
            n.h = 0;
            n.v = (n.v == 5) ? 0 : n.v + 1;
        end
    endtask

    task automatic model_reset();
        ma = '{h: 0, v: 0, mode: 2'd0, color: 24'h0};
        mb = '{h: 0, v: 0, mode: 2'd0, color: 24'h0};
        q_a.delete();
        q_b.delete();
    endtask

    // Drive inputs at the falling edge and queue what the next rising edge must present.
    task automatic tick();
        mstate_t n;
        pix_t    p;
        @(negedge clk);
        if (rel_pending) begin
            rst = 1'b0;
            rel_pending = 1'b0;
        end
        mode  = nxt_mode;
        color = nxt_color;
        if (!rst) begin
            step(ma, 8, 10, 12, n, p);
            ma = n;
            q_a.push_back(p);
            step(mb, 512, 514, 520, n, p);
            mb = n;
            q_b.push_back(p);
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic wait_pos(input int h, input int v);
        int budget;
        budget = 200;
        while (!(ma.h == h && ma.v == v) && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            checks++;
            failures++;
            $display("FAIL wait_pos(%0d,%0d): position never reached", h, v);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_outputs"}, {4'(0), vid_a.sof, vid_a.hs, vid_a.vs, vid_a.de, vid_a.data},
            32'h0);
        chk({tag, "_b_outputs"}, {4'(0), vid_b.sof, vid_b.hs, vid_b.vs, vid_b.de, vid_b.data},
            32'h0);
    endtask

    // Monitor: pops one expectation per DUT per active edge and tracks the sof period.
    initial begin
        pix_t exp_p;
        pix_t act_p;
        int   since_sof;
        bit   sof_seen;
        since_sof = 0;
        sof_seen  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                sof_seen  = 1'b0;
                since_sof = 0;
            end else begin
                act_p = {vid_a.sof, vid_a.hs, vid_a.vs, vid_a.de, vid_a.data};
                if (q_a.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut_a_queue: output with no expectation at %0t", $time);
                end else begin
                    exp_p = q_a.pop_front();
                    chk("dut_a_pixel", 32'(act_p), 32'(exp_p));
                end
                act_p = {vid_b.sof, vid_b.hs, vid_b.vs, vid_b.de, vid_b.data};
                if (q_b.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dut_b_queue: output with no expectation at %0t", $time);
                end else begin
                    exp_p = q_b.pop_front();
                    chk("dut_b_pixel", 32'(act_p), 32'(exp_p));
                end
                since_sof++;
                if (vid_a.sof) begin
                    if (sof_seen) chk("sof_period", 32'(since_sof), 32'd72);
                    sof_seen  = 1'b1;
                    since_sof = 0;
                end
            end
        end
    end

    initial begin
        model_reset();
        nxt_mode  = 2'($urandom_range(0, 3));
        nxt_color = 24'($urandom);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rel_pending = 1'b1;

        // Raster timing over three frames, then every mode for several frames.
        nxt_mode  = 2'd0;
        nxt_color = 24'h5A5A5A;
        run(3 * 72);
        for (int m = 0; m < 4; m++) begin
            nxt_mode  = 2'(m);
            nxt_color = 24'($urandom);
            run(3 * 72);
        end

        // SOLID colour change mid-frame must wait for the next frame.
        nxt_mode  = 2'd0;
        nxt_color = 24'h123456;
        wait_pos(0, 0);
        tick();
        wait_pos(3, 1);
        nxt_color = 24'hABCDEF;
        run(2 * 72);

        // Randomised mode/colour changes at arbitrary points.
        for (int i = 0; i < 15; i++) begin
            nxt_mode  = 2'($urandom_range(0, 3));
            nxt_color = 24'($urandom);
            run($urandom_range(10, 150));
        end

        // Two full frames of the wide instance in RAMP.
        nxt_mode = 2'd3;
        run(2 * 520 * 6 + 20);

        // Asynchronous reset while pixel (5,2) is on the outputs.
        nxt_mode  = 2'd1;
        nxt_color = 24'($urandom);
        wait_pos(6, 2);
        @(posedge clk);
        #2;
        chk("pre_reset_de", 32'(vid_a.de), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("async_reset");
        model_reset();
        repeat (2) @(negedge clk);
        rel_pending = 1'b1;
        nxt_mode    = 2'($urandom_range(0, 3));
        nxt_color   = 24'($urandom);
        run(3 * 72);

        for (int i = 0; i < 6; i++) begin
            nxt_mode  = 2'($urandom_range(0, 3));
            nxt_color = 24'($urandom);
            run($urandom_range(40, 200));
        end

        @(posedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
